// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared pipeline types and width defaults for the MEM stage
package mem_access_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic regWrite;
    } mem_ctrl_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus; master = MEM stage, slave = memory
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [DATA_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic              dmem_ack_i;
    logic [DATA_W-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - BUSY-cycle counter with clear/enable and expire on the last allowed cycle
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expire only while counting so an idle counter sitting at LAST
    // (TIMEOUT_CYC == 1) never fires outside BUSY.
    assign expire = en & (cnt == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage FSM and MEM/WB register; MEM_ALIGN_CHK_EN rejects misaligned accesses
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                memRead_i,
    input  logic                memWrite_i,
    input  logic                memToReg_i,
    input  logic                regWrite_i,
    input  logic [DATA_W-1:0]   aluResult_i,
    input  logic [DATA_W-1:0]   rtData_i,
    input  logic [REG_AW-1:0]   wbAddr_i,
    mem_access_stage_if.master  dmem,
    output logic                stall_o,
    output logic                err_o,
    output logic                regWrite_o,
    output logic [REG_AW-1:0]   wbAddr_o,
    output logic [DATA_W-1:0]   wbData_o
);

    state_t             state;
    mem_ctrl_t          in_ctrl;
    logic               cap_mem_to_reg;
    logic               cap_reg_write;
    logic [REG_AW-1:0]  cap_wb_addr;

    logic busy;
    logic access;
    logic misaligned;
    logic issue;
    logic align_err;
    logic ack;
    logic expire;
    logic ctr_clr;

    assign in_ctrl = '{memRead:  memRead_i,
                       memWrite: memWrite_i,
                       memToReg: memToReg_i,
                       regWrite: regWrite_i};

    assign busy   = (state == BUSY);
    assign access = in_ctrl.memRead | in_ctrl.memWrite;

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = |aluResult_i[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign issue     = ~busy & access & ~misaligned;
    assign align_err = ~busy & access & misaligned;
    // Ack is only meaningful in BUSY; a stray pulse in IDLE is dropped here.
    assign ack       = busy & dmem.dmem_ack_i;
    // Ack takes priority over timeout, so expire only matters without ack.
    assign stall_o   = issue | (busy & ~ack & ~expire);
    assign ctr_clr   = ~busy | ack | expire;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clr    (ctr_clr),
        .en     (busy),
        .expire (expire)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state             <= IDLE;
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_addr_o  <= '0;
            dmem.dmem_wdata_o <= '0;
            cap_mem_to_reg    <= 1'b0;
            cap_reg_write     <= 1'b0;
            cap_wb_addr       <= '0;
            err_o             <= 1'b0;
            regWrite_o        <= 1'b0;
            wbAddr_o          <= '0;
            wbData_o          <= '0;
        end else begin
            // Bubble unless a branch below writes a real result.
            err_o      <= 1'b0;
            regWrite_o <= 1'b0;
            wbAddr_o   <= '0;
            wbData_o   <= '0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state             <= BUSY;
                        dmem.dmem_req_o   <= 1'b1;
                        dmem.dmem_we_o    <= in_ctrl.memWrite;
                        dmem.dmem_addr_o  <= aluResult_i;
                        dmem.dmem_wdata_o <= rtData_i;
                        cap_mem_to_reg    <= in_ctrl.memToReg;
                        cap_reg_write     <= in_ctrl.regWrite;
                        cap_wb_addr       <= wbAddr_i;
                    end else if (align_err) begin
                        err_o <= 1'b1;
                    end else begin
                        regWrite_o <= in_ctrl.regWrite;
                        wbAddr_o   <= wbAddr_i;
                        wbData_o   <= aluResult_i;
                    end
                end
                BUSY: begin
                    if (ack) begin
                        state           <= IDLE;
                        dmem.dmem_req_o <= 1'b0;
                        regWrite_o      <= cap_reg_write;
                        wbAddr_o        <= cap_wb_addr;
                        wbData_o        <= cap_mem_to_reg ? dmem.dmem_rdata_i : dmem.dmem_addr_o;
                    end else if (expire) begin
                        state           <= IDLE;
                        dmem.dmem_req_o <= 1'b0;
                        err_o           <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
